filter_tap_sequencer: RTL and testbench
=======================================

# filter_tap_sequencer

FIR tap sequencer that sits directly upstream of `filter_accumulator`. Accepts one unsigned sample per handshake and stores it in a circular delay line. It then streams the TAPS coefficient×sample products into the accumulator's `D`/`load`/`enable` inputs, one product per cycle. When the accumulator's `Q` holds the finished output sample, it flags `result_valid`.

## Interface
- `TAPS`, 8: number of taps; power of two, 2..16. The 16-bit × 16-tap worst case fits the 20-bit accumulator.
- `DATA_W`, 8: sample width, unsigned.
- `COEF_W`, 8: coefficient width, unsigned. DATA_W+COEF_W = 16, matching accumulator `D`.
- `clk`  in  1  rising-edge clock shared with `filter_accumulator`.
- `rst`  in  1  synchronous, active-high reset. The top level drives accumulator `rst_n` = ~`rst`.
- `sample_valid`  in  1  upstream sample offered.
- `sample_in`  in  DATA_W  sample value.
- `sample_ready`  out  1  high only in IDLE; a transfer occurs when valid&ready at a rising edge.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  log2(TAPS)  tap index k.
- `coef_data`  in  COEF_W  coefficient h[k].
- `acc_enable`  out  1  to accumulator `enable`.
- `acc_load`  out  1  to accumulator `load`.
- `acc_d`  out  16  to accumulator `D`; carries the product h[k]·x[n−k].
- `result_valid`  out  1  one-cycle pulse: accumulator `Q` = y[n] during this cycle.
- `busy`  out  1  high in RUN and DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `sample_ready`=1; all accumulator outputs are 0, so the accumulator holds.
  - On a transfer: write `sample_in` to the delay line at `wr_ptr`, latch `newest`=`wr_ptr`, advance `wr_ptr` mod TAPS, set k=0, go to RUN.
- RUN, each cycle:
  - Register `acc_d` = h[k]·x[(newest−k) mod TAPS], `acc_enable`=1, `acc_load`=(k==0).
  - Increment k. After issuing k=TAPS−1, go to DONE.
- DONE: register all accumulator outputs to 0, pulse `result_valid`, go to IDLE.
- Arithmetic:
  - Unsigned DATA_W×COEF_W multiply, full 16-bit product, no truncation.
  - Read index wraps naturally because TAPS is a power of two.
- Delay line and coefficient file both reset to all zeros, so early outputs see zero history.
- Coefficient writes:
  - Accepted only when `busy`=0.
  - `coef_we` while busy is ignored; the write is not queued.
  - A write in the same cycle as a sample transfer is accepted, and the new coefficient is used for that sample.
- `sample_valid` while busy is not accepted, and `sample_in` is not sampled.
- `rst` in any state, on the next edge:
  - state → IDLE, k=0, `wr_ptr`=0.
  - Delay line and coefficients cleared.
  - All outputs take their reset values.

## Timing
- Reset values: `sample_ready`=0 during reset, then 1 the cycle after `rst` deasserts. `acc_enable`=0, `acc_load`=0, `acc_d`=0, `result_valid`=0, `busy`=0.
- Let E0 be the transfer edge.
- `acc_*` carry tap k in the cycle following edge E(k+1), for k = 0..TAPS−1. `acc_load` is high only for tap 0.
- The accumulator captures tap k at E(k+2). `Q` = y[n] after E(TAPS+1).
- `result_valid` is high for exactly the cycle after E(TAPS+1).
- `sample_ready` returns at E(TAPS+2), giving a throughput of one sample per TAPS+2 cycles.
- Latency from transfer to `result_valid` is TAPS+1 cycles.
- With `sample_valid` held high, the next transfer occurs at E(TAPS+2).

## Structure
- Package `filter_pkg`: TAPS, DATA_W, COEF_W, ACC_D_W=16, ACC_Q_W=20, FSM state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2), derived PTR_W=log2(TAPS).
- Sub-module `filter_delay_line`: a TAPS×DATA_W register array.
  - One write port: `we`, `wr_data`.
  - Internal `wr_ptr`; outputs `newest`.
  - One combinational read port addressed by offset k.
  - Synchronous clear on `rst`.
- The top-level sequencer holds the FSM, tap counter, coefficient file, multiplier and output registers.

## Test plan
- **Impulse:** h = 1..8, samples 1,0,0,…,0 (10 samples) → `Q` at each `result_valid` = 1,2,3,4,5,6,7,8,0,0.
- **Moving sum:** all h=1, samples 1,2,3 from reset → `Q` = 1, 3, 6.
- **Full-scale:** all h=255, nine samples of 255 → ninth `Q` = 520200 (20'h7F008), no overflow.
- **Handshake:** `sample_valid` held high, samples 1..4, h=1 → transfers exactly 10 cycles apart, `result_valid` 9 cycles after each transfer, `Q` = 1,3,6,10.
- **Coefficient write while busy:** h[0] 2→7 during RUN, samples 5,5, other h=0 → first `Q` = 10, second `Q` = 10 (write ignored). Re-write h[0]=7 in IDLE → next `Q` = 35.
- **Mid-run reset:** assert `rst` at tap 3 → next cycle `busy`=0, `acc_enable`=0, no `result_valid`. Reload h=1, sample 4 → `Q` = 4 (history cleared).

Source files
------------

// File: rtl/filter_pkg.sv
// Shared sizing, accumulator widths and sequencer state encoding for the FIR tap path.
package filter_pkg;
    localparam int TAPS    = 8;
    localparam int DATA_W  = 8;
    localparam int COEF_W  = 8;
    localparam int ACC_D_W = 16;
    localparam int ACC_Q_W = 20;
    localparam int PTR_W   = $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/filter_delay_line.sv
// Circular TAPS-deep sample history; write is registered, read by offset from newest is combinational.
// Accepts a write whenever i_we is high; no backpressure of its own.
module filter_delay_line
    import filter_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [PTR_W-1:0]  i_rd_off,
    output logic [PTR_W-1:0]  o_newest,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [TAPS];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_newest;
    logic [PTR_W-1:0]  w_rd_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_newest <= '0;
        end else if (i_we) begin
            r_mem[r_wr_ptr] <= i_wr_data;
            r_newest        <= r_wr_ptr;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        end
    end

    // TAPS is a power of two, so the subtraction wraps to the right slot for free.
    assign w_rd_idx  = r_newest - i_rd_off;
    assign o_rd_data = r_mem[w_rd_idx];
    assign o_newest  = r_newest;
endmodule

// File: rtl/filter_tap_sequencer.sv
// Streams TAPS coefficient*sample products into the accumulator, one per cycle; result_valid TAPS+1 cycles after transfer.
// Takes a new sample only in IDLE (one per TAPS+2 cycles); coefficient writes while busy are dropped.
module filter_tap_sequencer
    import filter_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sample_valid,
    input  logic [DATA_W-1:0]  i_sample_in,
    output logic               o_sample_ready,
    input  logic               i_coef_we,
    input  logic [PTR_W-1:0]   i_coef_addr,
    input  logic [COEF_W-1:0]  i_coef_data,
    output logic               o_acc_enable,
    output logic               o_acc_load,
    output logic [ACC_D_W-1:0] o_acc_d,
    output logic               o_result_valid,
    output logic               o_busy
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_k;
    logic [PTR_W-1:0]   w_k_nxt;
    logic [COEF_W-1:0]  r_coef [TAPS];
    logic               r_sample_ready;
    logic               r_acc_enable;
    logic               r_acc_load;
    logic [ACC_D_W-1:0] r_acc_d;
    logic               r_result_valid;

    logic               w_xfer;
    logic               w_coef_wr;
    logic [PTR_W-1:0]   w_newest;
    logic [DATA_W-1:0]  w_rd_data;
    logic [ACC_D_W-1:0] w_product;
    logic               w_en_nxt;
    logic               w_load_nxt;
    logic [ACC_D_W-1:0] w_d_nxt;
    logic               w_rv_nxt;

    assign w_xfer    = i_sample_valid & r_sample_ready;
    assign w_coef_wr = i_coef_we & (r_state == IDLE);

    filter_delay_line u_delay_line (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_xfer),
        .i_wr_data (i_sample_in),
        .i_rd_off  (r_k),
        .o_newest  (w_newest),
        .o_rd_data (w_rd_data)
    );

    assign w_product = ACC_D_W'(r_coef[r_k]) * ACC_D_W'(w_rd_data);

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_en_nxt    = 1'b0;
        w_load_nxt  = 1'b0;
        w_d_nxt     = '0;
        w_rv_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = RUN;
                    w_k_nxt     = '0;
                end
            end
            RUN: begin
                w_en_nxt   = 1'b1;
                w_load_nxt = (r_k == '0);
                w_d_nxt    = w_product;
                w_k_nxt    = r_k + PTR_W'(1);
                if (r_k == PTR_W'(TAPS - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // Last tap lands in the accumulator at this edge, so Q is final next cycle.
                w_rv_nxt    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_k            <= '0;
            r_sample_ready <= 1'b0;
            r_acc_enable   <= 1'b0;
            r_acc_load     <= 1'b0;
            r_acc_d        <= '0;
            r_result_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            r_state        <= w_state_nxt;
            r_k            <= w_k_nxt;
            r_sample_ready <= (w_state_nxt == IDLE);
            r_acc_enable   <= w_en_nxt;
            r_acc_load     <= w_load_nxt;
            r_acc_d        <= w_d_nxt;
            r_result_valid <= w_rv_nxt;
            if (w_coef_wr) begin
                r_coef[i_coef_addr] <= i_coef_data;
            end
        end
    end

    assign o_sample_ready = r_sample_ready;
    assign o_acc_enable   = r_acc_enable;
    assign o_acc_load     = r_acc_load;
    assign o_acc_d        = r_acc_d;
    assign o_result_valid = r_result_valid;
    assign o_busy         = (r_state != IDLE);
endmodule

// File: tb/tb_filter_tap_sequencer.sv
// Directed bench for filter_tap_sequencer with a behavioural accumulator on its acc_* outputs.
module tb_filter_tap_sequencer;
    import filter_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sample_valid = 1'b0;
    logic [DATA_W-1:0]  sample_in = '0;
    logic               coef_we = 1'b0;
    logic [PTR_W-1:0]   coef_addr = '0;
    logic [COEF_W-1:0]  coef_data = '0;
    logic               sample_ready;
    logic               acc_enable;
    logic               acc_load;
    logic [ACC_D_W-1:0] acc_d;
    logic               result_valid;
    logic               busy;
    logic [ACC_Q_W-1:0] acc_q;

    int checks = 0;
    int errors = 0;
    logic t0_en, t0_load, t1_load;
    logic [ACC_D_W-1:0] t0_d;

    always #5 clk = ~clk;

    filter_tap_sequencer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sample_valid (sample_valid),
        .i_sample_in    (sample_in),
        .o_sample_ready (sample_ready),
        .i_coef_we      (coef_we),
        .i_coef_addr    (coef_addr),
        .i_coef_data    (coef_data),
        .o_acc_enable   (acc_enable),
        .o_acc_load     (acc_load),
        .o_acc_d        (acc_d),
        .o_result_valid (result_valid),
        .o_busy         (busy)
    );

    // Downstream accumulator: load replaces, enable alone adds.
    always @(posedge clk) begin
        if (rst)
            acc_q <= '0;
        else if (acc_enable)
            acc_q <= acc_load ? ACC_Q_W'(acc_d) : acc_q + ACC_Q_W'(acc_d);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        sample_valid = 1'b0;
        coef_we = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic write_coef(input int k, input int v);
        coef_we = 1'b1;
        coef_addr = PTR_W'(k);
        coef_data = COEF_W'(v);
        tick;
        coef_we = 1'b0;
    endtask

    // mode 0: plain; 1: try h[0]=7 while running; 2: write h[0]=3 on the transfer edge
    task automatic send_sample(input int v, input int exp_q, input int mode, input string tag);
        int n;
        n = 0;
        while (!sample_ready && n < 30) begin
            tick;
            n++;
        end
        check({tag, "_rdy"}, 32'(sample_ready), 32'd1);
        sample_valid = 1'b1;
        sample_in = DATA_W'(v);
        if (mode == 2) begin
            coef_we = 1'b1;
            coef_addr = '0;
            coef_data = 8'd3;
        end
        tick;
        sample_valid = 1'b0;
        coef_we = 1'b0;
        n = 0;
        while (n < 20) begin
            if (mode == 1 && n == 2) begin
                coef_we = 1'b1;
                coef_addr = '0;
                coef_data = 8'd7;
            end
            tick;
            n++;
            coef_we = 1'b0;
            if (n == 1) begin
                t0_en = acc_enable;
                t0_load = acc_load;
                t0_d = acc_d;
            end
            if (n == 2) t1_load = acc_load;
            if (result_valid) break;
        end
        check({tag, "_lat"}, 32'(n), 32'd9);
        check({tag, "_q"}, 32'(acc_q), 32'(exp_q));
    endtask

    initial begin
        int xfer_t[$];
        int rv_t[$];
        int qs[$];
        int exp_hs[4];
        int nx;
        int rv_cnt;
        logic pre;

        // Reset values
        rst = 1'b1;
        tick;
        tick;
        check("rst_ready", 32'(sample_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(acc_enable), 32'd0);
        check("rst_load", 32'(acc_load), 32'd0);
        check("rst_d", 32'(acc_d), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        rst = 1'b0;
        tick;
        check("rst_ready_after", 32'(sample_ready), 32'd1);

        // Impulse: h = 1..8
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        send_sample(1, 1, 0, "imp0");
        check("imp0_tap0_en", 32'(t0_en), 32'd1);
        check("imp0_tap0_load", 32'(t0_load), 32'd1);
        check("imp0_tap0_d", 32'(t0_d), 32'd1);
        check("imp0_tap1_load", 32'(t1_load), 32'd0);
        for (int i = 1; i < 10; i++)
            send_sample(0, (i < 8) ? i + 1 : 0, 0, $sformatf("imp%0d", i));

        // Moving sum
        do_reset;
        for (int k = 0; k < TAPS; k++) write_coef(k, 1);
        send_sample(1, 1, 0, "ms0");
        send_sample(2, 3, 0, "ms1");
        send_sample(3, 6, 0, "ms2");

        // Full scale
        do_reset;
        for (int k = 0; k < TAPS; k++) write_coef(k, 255);
        for (int i = 0; i < 9; i++)
            send_sample(255, ((i < 8) ? i + 1 : 8) * 65025, 0, $sformatf("fs%0d", i));

        // Handshake with valid held high
        do_reset;
        for (int k = 0; k < TAPS; k++) write_coef(k, 1);
        exp_hs = '{1, 3, 6, 10};
        nx = 0;
        sample_valid = 1'b1;
        sample_in = 8'd1;
        for (int c = 1; c <= 60; c++) begin
            pre = sample_ready;
            tick;
            if (pre && sample_valid) begin
                xfer_t.push_back(c);
                nx++;
                if (nx == 4) sample_valid = 1'b0;
                else sample_in = DATA_W'(nx + 1);
            end
            if (result_valid) begin
                rv_t.push_back(c);
                qs.push_back(int'(acc_q));
            end
        end
        sample_valid = 1'b0;
        check("hs_xfers", 32'(xfer_t.size()), 32'd4);
        check("hs_results", 32'(rv_t.size()), 32'd4);
        for (int i = 0; i < 4 && i < xfer_t.size() && i < rv_t.size(); i++) begin
            if (i > 0) check($sformatf("hs_gap%0d", i), 32'(xfer_t[i] - xfer_t[i-1]), 32'd10);
            check($sformatf("hs_lat%0d", i), 32'(rv_t[i] - xfer_t[i]), 32'd9);
            check($sformatf("hs_q%0d", i), 32'(qs[i]), 32'(exp_hs[i]));
        end

        // Coefficient writes vs busy
        do_reset;
        write_coef(0, 2);
        send_sample(5, 10, 1, "cw_busy");
        send_sample(5, 10, 0, "cw_ignored");
        write_coef(0, 7);
        send_sample(5, 35, 0, "cw_idle");
        send_sample(2, 6, 2, "cw_same_edge");

        // Mid-run reset
        do_reset;
        for (int k = 0; k < TAPS; k++) write_coef(k, 1);
        send_sample(7, 7, 0, "mr_pre");
        sample_valid = 1'b1;
        sample_in = 8'd3;
        tick;
        sample_valid = 1'b0;
        repeat (4) tick;
        check("mr_tap3_en", 32'(acc_enable), 32'd1);
        check("mr_tap3_load", 32'(acc_load), 32'd0);
        rst = 1'b1;
        tick;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_en", 32'(acc_enable), 32'd0);
        check("mr_rv", 32'(result_valid), 32'd0);
        rst = 1'b0;
        rv_cnt = 0;
        repeat (12) begin
            tick;
            if (result_valid) rv_cnt++;
        end
        check("mr_no_rv", 32'(rv_cnt), 32'd0);
        for (int k = 0; k < TAPS; k++) write_coef(k, 1);
        send_sample(4, 4, 0, "mr_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
